// File: rtl/hll_bucket_update.sv
// hll_bucket_update: HyperLogLog max-rank register file fed by a hash stream, with clear sweep and valid/ready drain
module hll_bucket_update #(
   parameter int P      = 14,
   parameter int RANK_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [63:0]       hash,
   input  logic              in_valid,
   input  logic              clear,
   input  logic              drain_req,
   output logic [P-1:0]      out_idx,
   output logic [RANK_W-1:0] out_rank,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              done,
   output logic              busy,
   output logic [31:0]       drop_cnt
);
   localparam int W = 64 - P;
   typedef enum logic [1:0] {S_CLEAR, S_RUN, S_DWAIT, S_DRAIN} state_t;
   state_t            state_q, state_d;
   logic [P:0]        cnt_q, cnt_d;
   logic              a_valid_q, a_valid_d, b_valid_q, b_valid_d, p_valid_q, p_valid_d;
   logic [P-1:0]      a_idx_q, a_idx_d, b_idx_q, b_idx_d, p_idx_q, p_idx_d;
   logic [RANK_W-1:0] a_rank_q, a_rank_d, b_rank_q, b_rank_d, rd_q;
   logic              out_valid_q, out_valid_d, done_q, done_d, busy_q, busy_d;
   logic [P-1:0]      out_idx_q, out_idx_d;
   logic [RANK_W-1:0] out_rank_q, out_rank_d;
   logic [31:0]       drop_q, drop_d;
   logic [RANK_W-1:0] mem [2**P];
   logic [P-1:0]      h_idx, wa, ra;
   logic [RANK_W-1:0] h_rank, old_rank, new_rank, wd;
   logic              fire, load, issue, we, re;

   always_comb begin
      h_idx  = hash[63 -: P];
      h_rank = RANK_W'(W + 1);
      for (int i = 0; i < W; i++)
         if (hash[i]) h_rank = RANK_W'(W - i);
   end

   // Stage B holds last cycle's write, which the RAM word read by stage A cannot yet reflect
   assign old_rank = (b_valid_q && b_idx_q == a_idx_q) ? b_rank_q : rd_q;
   assign new_rank = (a_rank_q > old_rank) ? a_rank_q : old_rank;
   assign fire     = out_valid_q && out_ready;
   assign load     = p_valid_q && (!out_valid_q || fire);
   assign issue    = state_q == S_DRAIN && !cnt_q[P] && (!p_valid_q || load);
   assign we       = state_q == S_CLEAR || a_valid_q;
   assign wa       = state_q == S_CLEAR ? cnt_q[P-1:0] : a_idx_q;
   assign wd       = state_q == S_CLEAR ? '0 : new_rank;
   assign re       = issue || (state_q == S_RUN && in_valid);
   assign ra       = state_q == S_DRAIN ? cnt_q[P-1:0] : h_idx;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_valid_d   = state_q == S_RUN && in_valid;
      a_idx_d     = h_idx;
      a_rank_d    = h_rank;
      b_valid_d   = a_valid_q && state_q != S_CLEAR;
      b_idx_d     = a_idx_q;
      b_rank_d    = new_rank;
      p_valid_d   = issue ? 1'b1 : (load ? 1'b0 : p_valid_q);
      p_idx_d     = issue ? cnt_q[P-1:0] : p_idx_q;
      out_valid_d = load ? 1'b1 : (fire ? 1'b0 : out_valid_q);
      out_idx_d   = load ? p_idx_q : out_idx_q;
      out_rank_d  = load ? rd_q : out_rank_q;
      done_d      = 1'b0;
      drop_d      = (in_valid && state_q != S_RUN && drop_q != '1) ? drop_q + 32'd1 : drop_q;
      case (state_q)
         S_CLEAR: begin
            cnt_d = cnt_q + (P+1)'(1);
            if (cnt_q[P-1:0] == '1) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            cnt_d = '0;
            if (clear) state_d = S_CLEAR;
            else if (drain_req) state_d = S_DWAIT;
         end
         S_DWAIT: begin
            cnt_d = '0;
            if (!a_valid_q && !b_valid_q) state_d = S_DRAIN;
         end
         default: begin
            if (issue) cnt_d = cnt_q + (P+1)'(1);
            if (fire && out_idx_q == {P{1'b1}}) begin
               state_d   = S_RUN;
               done_d    = 1'b1;
               cnt_d     = '0;
               p_valid_d = 1'b0;
            end
         end
      endcase
      busy_d = state_d != S_RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_CLEAR;
         cnt_q       <= '0;
         a_valid_q   <= 1'b0;
         a_idx_q     <= '0;
         a_rank_q    <= '0;
         b_valid_q   <= 1'b0;
         b_idx_q     <= '0;
         b_rank_q    <= '0;
         p_valid_q   <= 1'b0;
         p_idx_q     <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_rank_q  <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b1;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_valid_q   <= a_valid_d;
         a_idx_q     <= a_idx_d;
         a_rank_q    <= a_rank_d;
         b_valid_q   <= b_valid_d;
         b_idx_q     <= b_idx_d;
         b_rank_q    <= b_rank_d;
         p_valid_q   <= p_valid_d;
         p_idx_q     <= p_idx_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_rank_q  <= out_rank_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         drop_q      <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      if (re) rd_q <= mem[ra];
   end

   assign out_idx   = out_idx_q;
   assign out_rank  = out_rank_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_hll_bucket_update.sv
// tb_hll_bucket_update: vector tables, hand sequences and random hashes against a bucket-array model
module tb_hll_bucket_update;
   localparam int P = 4, RW = 6, N = 16;
   typedef struct {logic [63:0] h; int idx; int rank;} vec_t;
   logic clk = 0, rst_n = 0, in_valid = 0, clear = 0, drain_req = 0, out_ready = 0;
   logic [63:0] hash = '0;
   logic [P-1:0] out_idx;
   logic [RW-1:0] out_rank;
   logic out_valid, done, busy;
   logic [31:0] drop_cnt;
   int vectors = 0, miscompares = 0, drops_exp = 0, n, ov;
   int model[N];
   int got[N];
   vec_t tv[3];
   vec_t seq[3];

   always #5 clk = ~clk;

   hll_bucket_update #(.P(P), .RANK_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .hash(hash), .in_valid(in_valid), .clear(clear),
      .drain_req(drain_req), .out_idx(out_idx), .out_rank(out_rank), .out_valid(out_valid),
      .out_ready(out_ready), .done(done), .busy(busy), .drop_cnt(drop_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // rank = leading zeros of the low 64-P bits plus one, via bit length of w
   function automatic int ref_rank(input logic [63:0] h);
      logic [63:0] w;
      w = h & ((64'd1 << (64 - P)) - 64'd1);
      return (64 - P + 1) - $clog2(w + 64'd1);
   endfunction

   task automatic apply(input logic [63:0] h, input bit accepted);
      int i, r;
      hash = h;
      in_valid = 1;
      i = int'(h >> (64 - P));
      r = ref_rank(h);
      if (accepted) model[i] = (r > model[i]) ? r : model[i];
      else drops_exp++;
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic zero_model();
      for (int i = 0; i < N; i++) model[i] = 0;
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (busy && cnt < 1000) begin
         @(negedge clk);
         cnt++;
      end
      if (busy) chk("busy_timeout", busy, 0);
   endtask

   task automatic pulse_clear();
      clear = 1;
      @(negedge clk);
      clear = 0;
      zero_model();
   endtask

   task automatic drain(input bit rnd_ready, input int drop_pulses);
      int exp_idx = 0, dones = 0, cyc = 0, extra = 0, pulses = drop_pulses;
      bit pv = 0, acc_prev = 1;
      logic [P-1:0] pidx = '0;
      logic [RW-1:0] prank = '0;
      drain_req = 1;
      @(negedge clk);
      drain_req = 0;
      while ((exp_idx < N || dones == 0) && cyc < 300) begin
         if (pulses > 0) begin
            hash = 64'h5000_0000_0000_0000;
            in_valid = 1;
            pulses--;
            drops_exp++;
         end else in_valid = 0;
         if (done) dones++;
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid) begin
            if (pv && !acc_prev) begin
               chk("hold_idx", out_idx, pidx);
               chk("hold_rank", out_rank, prank);
            end
            if (out_ready) begin
               chk("beat_idx", out_idx, exp_idx);
               if (exp_idx < N) begin
                  chk("beat_rank", out_rank, model[exp_idx]);
                  got[exp_idx] = out_rank;
               end
               exp_idx++;
            end
            acc_prev = out_ready;
            pv = 1;
            pidx = out_idx;
            prank = out_rank;
         end else pv = 0;
         @(negedge clk);
         cyc++;
      end
      in_valid = 0;
      out_ready = 0;
      repeat (3) begin
         if (done) dones++;
         if (out_valid) extra++;
         @(negedge clk);
      end
      chk("drain_beats", exp_idx, N);
      chk("done_once", dones, 1);
      chk("no_extra_valid", extra, 0);
   endtask

   initial begin
      tv[0] = '{64'hF000_0000_0000_0001, 15, 60};
      tv[1] = '{64'h0800_0000_0000_0000, 0, 1};
      tv[2] = '{64'h1000_0000_0000_0000, 1, 61};
      seq[0] = '{64'h3080_0000_0000_0000, 3, 5};
      seq[1] = '{64'h3400_0000_0000_0000, 3, 2};
      seq[2] = '{64'h3008_0000_0000_0000, 3, 9};
      zero_model();
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 1);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_rank", out_rank, 0);
      rst_n = 1;
      wait_idle(n);
      chk("clear_cycles", n, 16);
      drain(0, 0);

      for (int k = 0; k < 3; k++) begin
         apply(tv[k].h, 1);
         repeat (3) @(negedge clk);
      end
      drain(0, 0);
      for (int k = 0; k < 3; k++) chk("table_bucket", got[tv[k].idx], tv[k].rank);

      pulse_clear();
      wait_idle(n);
      for (int k = 0; k < 3; k++) apply(seq[k].h, 1);
      repeat (3) @(negedge clk);
      drain(0, 0);
      chk("b2b_bucket3", got[3], 9);
      pulse_clear();
      wait_idle(n);
      for (int k = 2; k >= 0; k--) apply(seq[k].h, 1);
      drain(0, 0);
      chk("b2b_rev_bucket3", got[3], 9);

      for (int k = 0; k < 80; k++) begin
         logic [63:0] w;
         logic [3:0] ix;
         ix = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
         w = {$urandom, $urandom} >> $urandom_range(4, 64);
         apply({ix, w[59:0]}, 1);
         if ($urandom_range(0, 2) == 0) @(negedge clk);
      end
      drain(1, 0);
      drain(1, 0);

      pulse_clear();
      for (int k = 0; k < 5; k++) begin
         apply(64'hF000_0000_0000_0000, 0);
         @(negedge clk);
      end
      wait_idle(n);
      apply(64'h2100_0000_0000_0000, 1);
      repeat (3) @(negedge clk);
      drain(1, 3);
      chk("drop_cnt_8", drop_cnt, 8);
      chk("drop_cnt_model", drop_cnt, drops_exp);

      clear = 1;
      drain_req = 1;
      @(negedge clk);
      clear = 0;
      drain_req = 0;
      zero_model();
      chk("clr_wins_busy", busy, 1);
      n = 0;
      ov = 0;
      while (busy && n < 100) begin
         if (out_valid) ov++;
         @(negedge clk);
         n++;
      end
      chk("clr_wins_cycles", n, 16);
      chk("clr_wins_no_valid", ov, 0);

      apply(64'h7000_0000_0000_0003, 1);
      repeat (3) @(negedge clk);
      drain_req = 1;
      @(negedge clk);
      drain_req = 0;
      out_ready = 1;
      repeat (8) @(negedge clk);
      chk("pre_reset_valid", out_valid, 1);
      #2 rst_n = 0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_busy", busy, 1);
      @(negedge clk);
      rst_n = 1;
      out_ready = 0;
      zero_model();
      drops_exp = 0;
      chk("drop_after_rst", drop_cnt, 0);
      wait_idle(n);
      chk("reclear_cycles", n, 16);
      drain(1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
